ble_at_uart_tx: RTL and testbench

BLE_AT_UART_TX -- requirements
Module: ble_at_uart_tx

---
 rtl/ble_pkg.sv | 24 ++
 rtl/ble_uart_byte_tx.sv | 101 ++++++++++
 rtl/ble_at_uart_tx.sv | 84 ++++++++
 tb/tb_ble_at_uart_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared constants and types for the BLE AT-command UART path (encoder and transmitter).
package ble_pkg;

  localparam int FRAME_W     = 128;
  localparam int FRAME_BYTES = 16;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bit period in clk cycles; a line rate faster than clk/2 is clamped.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    int r;
    r = clk_hz / baud;
    return (r < 2) ? 2 : r;
  endfunction

endpackage

// File: rtl/ble_uart_byte_tx.sv
// 8N1 byte serializer: START/DATA/STOP bit timing. A new byte is taken from IDLE on start,
// or straight from the end of a stop bit when more is set, so consecutive bytes have no gap.
module ble_uart_byte_tx
  import ble_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       more,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       idle,
  output logic       byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             tx_nxt;
  logic             wrap;

  assign wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign idle = (state == ST_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = baud_cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    byte_done = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = ST_START;
          sh_nxt    = byte_in;
        end
      end
      ST_START: begin
        if (wrap) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          cnt_nxt = '0;
          sh_nxt  = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          cnt_nxt   = '0;
          byte_done = 1'b1;
          if (more) begin
            state_nxt = ST_START;
            sh_nxt    = byte_in;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The line level is registered from the next state so tx never glitches.
    unique case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = sh_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= sh_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: rtl/ble_at_uart_tx.sv
// AT-frame UART transmitter: accepts a 128-bit frame and sends its 16 bytes MSB-byte first.
// Define BLE_AT_CRLF_EN to append CR LF after the last frame byte (18 characters per frame).
module ble_at_uart_tx
  import ble_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
`ifdef BLE_AT_CRLF_EN
  localparam int CHARS = FRAME_BYTES + 2;
`else
  localparam int CHARS = FRAME_BYTES;
`endif
  localparam int CHAR_W = $clog2(CHARS);

  logic [FRAME_W-1:0] frame_sr;
  logic [CHAR_W-1:0]  chars_left;
  logic               armed;
  logic               accept;
  logic               more;
  logic               idle;
  logic               byte_done;
  logic [7:0]         next_char;
  logic [7:0]         byte_in;

  // armed keeps frame_ready low until the first edge after reset release.
  assign frame_ready = armed & idle;
  assign accept      = frame_valid & frame_ready;
  assign more        = (chars_left != '0);
  assign busy        = ~idle;
  assign done        = byte_done & ~more;
  assign byte_in     = accept ? frame_data[FRAME_W-1 -: 8] : next_char;

  always_comb begin
    next_char = frame_sr[FRAME_W-1 -: 8];
`ifdef BLE_AT_CRLF_EN
    if (chars_left == CHAR_W'(2))      next_char = ASCII_CR;
    else if (chars_left == CHAR_W'(1)) next_char = ASCII_LF;
`endif
  end

  // NOTE: the frame shift register is cleared on reset so an aborted frame leaves no stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      frame_sr   <= '0;
      chars_left <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        frame_sr   <= {frame_data[FRAME_W-9:0], 8'h00};
        chars_left <= CHAR_W'(CHARS - 1);
      end else if (byte_done && more) begin
        frame_sr   <= {frame_sr[FRAME_W-9:0], 8'h00};
        chars_left <= chars_left - CHAR_W'(1);
      end
    end
  end

  ble_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .more     (more),
    .byte_in  (byte_in),
    .tx       (tx),
    .idle     (idle),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_ble_at_uart_tx.sv
// Randomized self-checking bench for ble_at_uart_tx; expected line levels come from a
// per-cycle arithmetic model of 8N1 framing (CLKS_PER_BIT = 4).
module tb_ble_at_uart_tx;

  localparam int CPB = 4;
`ifdef BLE_AT_CRLF_EN
  localparam int NCH = 18;
`else
  localparam int NCH = 16;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] frame_data = '0;
  logic         frame_valid = 1'b0;
  wire          frame_ready, tx, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_start = 0;
  int last_done  = 0;

  logic [7:0] rx_bytes [18];
  logic       first_bits [40];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ble_at_uart_tx #(.CLK_HZ(400), .BAUD(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Character k of the transmitted sequence for frame d.
  function automatic logic [7:0] char_of(input logic [127:0] d, input int k);
    if (k < 16)       return d[127 - 8*k -: 8];
    else if (k == 16) return 8'h0D;
    else              return 8'h0A;
  endfunction

  // Expected line level in cycle i (1 = first cycle after the accept edge).
  function automatic logic line_level(input logic [127:0] d, input int i);
    int         b;
    int         pos;
    logic [7:0] c;
    b   = (i - 1) / CPB;
    pos = b % 10;
    c   = char_of(d, b / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return c[pos - 1];
  endfunction

  // Offers frame d, then checks every cycle of its transmission. Entered and left at a negedge.
  task automatic send_frame(input logic [127:0] d, input bit chain, input logic [127:0] nd,
                            input int mutate_at, input int abort_at);
    int w;
    int b;
    int pos;
    int done_seen;
    int last;
    last      = NCH * CPB * 10;
    done_seen = 0;
    frame_data  = d;
    frame_valid = 1'b1;
    w = 0;
    while (!frame_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!frame_ready) begin
      check("accept_timeout", 0, 1);
      frame_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    frame_valid = chain;
    frame_data  = chain ? nd : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (i == 1) last_start = cyc;
      check("tx", tx, line_level(d, i));
      check("busy", busy, 1);
      check("frame_ready_busy", frame_ready, 0);
      check("done", done, (i == last));
      if (done) begin
        done_seen = i;
        last_done = cyc;
      end
      if ((i - 1) % CPB == 1) begin
        b   = (i - 1) / CPB;
        pos = b % 10;
        if (pos >= 1 && pos <= 8) rx_bytes[b / 10][pos - 1] = tx;
      end
      if (i <= 40) first_bits[i - 1] = tx;
      if (i == mutate_at) begin
        frame_data  = '1;
        frame_valid = 1'b1;
      end
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", frame_ready, 0);
        return;
      end
    end
    if (mutate_at != 0) frame_valid = 1'b0;
    check("done_cycle", done_seen, last);
    for (int k = 0; k < NCH; k++) check("rx_byte", rx_bytes[k], char_of(d, k));
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_ready", frame_ready, 1);
    check("post_tx", tx, 1);
  endtask

  initial begin
    logic [127:0] f1, fa, fb, fc, fd;
    logic [7:0]   gold [16];
    logic         pat [10];
    int           prev_done;

    gold = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41,
             8'h52, 8'h54, 8'h54, 8'h58, 8'h31, 8'h32, 8'h33, 8'h34};
    pat  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state, and frame_ready only after the first edge following release.
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", frame_ready, 0);
    reset = 1'b0;
    #1 check("ready_before_edge", frame_ready, 0);
    @(posedge clk);
    #1 check("ready_after_edge", frame_ready, 1);
    @(negedge clk);

    // Fixed AT frame; inputs overwritten with all-ones mid-frame.
    f1 = {"AT+BLEUARTTX", 32'h31323334};
    send_frame(f1, 1'b0, '0, 100, 0);
    for (int k = 0; k < 16; k++) check("gold_byte", rx_bytes[k], gold[k]);
    for (int c = 0; c < 40; c++) check("bit_0x41", first_bits[c], pat[c / CPB]);

    // Back-to-back random frames with frame_valid held high.
    fa = {$urandom, $urandom, $urandom, $urandom};
    fb = {$urandom, $urandom, $urandom, $urandom};
    send_frame(fa, 1'b1, fb, 0, 0);
    prev_done = last_done;
    send_frame(fb, 1'b0, '0, 0, 0);
    check("b2b_gap", last_start - prev_done, 2);

    // Mid-frame reset, then a clean frame after release.
    fc = {$urandom, $urandom, $urandom, $urandom};
    send_frame(fc, 1'b0, '0, 0, 300);
    repeat (3) begin
      @(negedge clk);
      check("in_rst_tx", tx, 1);
      check("in_rst_done", done, 0);
      check("in_rst_busy", busy, 0);
    end
    #2 reset = 1'b0;
    #1 check("rel_ready_early", frame_ready, 0);
    @(posedge clk);
    #1 check("rel_ready", frame_ready, 1);
    @(negedge clk);
    fd = {$urandom, $urandom, $urandom, $urandom};
    send_frame(fd, 1'b0, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
